clock_gen: RTL and testbench
============================

Name: clock_gen

Overview:
- Synthesizable, programmable clock generator driven by one reference clock.
- Toggles a generated clock `clk_out` every `hp` enabled reference cycles, so the output period is 2*hp reference cycles.
- Reload of `hp` is glitch-free.
- Also produces one-cycle edge-strobe pulses and a free-running output-period counter.
- Sits at the top of test/bring-up subsystems as the local tick/clock source for downstream logic.

Parameters:
- TICK_RATE, default 10: reset value of the half-period `hp`, in reference clock cycles; must be >=1.
- CNT_W, default 16: width of the half-period register and of the internal counter.

Ports:
- clk  input  1  reference clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; when low, all state holds.
- load  input  1  one-cycle strobe; captures half_period.
- half_period  input  CNT_W  new half-period value; 0 is clamped to 1.
- clk_out  output  1  generated clock (registered).
- tick_rise  output  1  one-cycle pulse in the cycle clk_out becomes 1.
- tick_fall  output  1  one-cycle pulse in the cycle clk_out becomes 0.
- period_count  output  32  number of clk_out rising transitions since reset; wraps modulo 2^32.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - clk_out=0, tick_rise=0, tick_fall=0, period_count=0.
  - Internal counter cnt=0, hp=TICK_RATE, pending=TICK_RATE.
  - Reset mid-operation discards any pending load.
- Enabled cycle (en=1), when cnt == hp-1:
  - cnt<=0 and clk_out<=~clk_out.
  - hp<=(load ? clamp(half_period) : pending).
  - tick_rise<=1 if clk_out was 0; tick_fall<=1 if clk_out was 1.
  - period_count increments on the rising transition.
- Enabled cycle, otherwise: cnt<=cnt+1; tick_rise and tick_fall <=0.
- en=0: cnt, clk_out, hp and period_count hold; tick_rise and tick_fall <=0. A load is still captured into pending.
- Load:
  - pending<=clamp(half_period), where clamp(0)=1 and any other value passes through.
  - The new value takes effect only at the next toggle, so the current half-period always completes at the old length (no runt pulses).
  - Multiple loads before a toggle: the last one wins.
- Latency: the first clk_out rise occurs at the TICK_RATE-th enabled rising clk edge after rst_n deasserts. Strobes are registered coincident with the clk_out change.
- hp=1: clk_out toggles every enabled cycle; tick_rise and tick_fall alternate every cycle.
- Counter width: cnt never exceeds hp-1; hp up to 2^CNT_W-1 supported.

Optional Feature:
- CLOCK_GEN_PERIOD_COUNT_EN defined: the 32-bit period_count register is implemented as specified.
- Not defined: no counter logic is built; period_count is tied to 32'd0. All other behaviour is unchanged.

Test Plan:
- Reset default: TICK_RATE=10, release rst_n, en=1 -> clk_out rises at 10th clk edge, falls at 20th, rises at 30th; tick_rise high exactly in cycles 10 and 30, tick_fall in cycle 20.
- Reload mid-half-period: load=1, half_period=3 at cycle 4 -> toggle still at cycle 10, next toggles at 13, 16, 19 (period 6).
- Zero clamp: load half_period=0 -> after the next toggle, clk_out toggles every cycle; tick_rise and tick_fall alternate each cycle.
- Enable gating: en=0 for 5 cycles at cycle 7 -> first toggle delayed to cycle 15; clk_out and cnt frozen; no strobes while en=0.
- Async reset mid-run: assert rst_n between clk edges while clk_out=1 and hp=3 -> clk_out=0, period_count=0 immediately; after release, first rise after 10 edges (hp back to TICK_RATE).
- Counter: with CLOCK_GEN_PERIOD_COUNT_EN and hp=1, run 8 cycles -> period_count=4; without the macro -> period_count stays 0.

Source files
------------

// File: rtl/clock_gen_if.sv
// Control and output bundle of the programmable clock generator.
// master drives enable/reload and observes the generated clock; slave is the generator.
interface clock_gen_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] half_period;
    logic             clk_out;
    logic             tick_rise;
    logic             tick_fall;
    logic [31:0]      period_count;

    modport master (
        output en,
        output load,
        output half_period,
        input  clk_out,
        input  tick_rise,
        input  tick_fall,
        input  period_count
    );

    modport slave (
        input  en,
        input  load,
        input  half_period,
        output clk_out,
        output tick_rise,
        output tick_fall,
        output period_count
    );
endinterface

// File: rtl/clock_gen.sv
// Programmable clock generator: clk_out toggles every hp enabled cycles, with edge strobes; CLOCK_GEN_PERIOD_COUNT_EN builds the rise counter.
// Latency: first rise on the TICK_RATE-th enabled edge after reset; strobes coincide with the clk_out change.
// Backpressure: none; en low freezes all state, while a load is still captured into pending.
module clock_gen #(
    parameter int TICK_RATE = 10,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    clock_gen_if.slave   bus
);
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HP_INIT = CNT_W'(TICK_RATE);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] load_val;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             toggle;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    assign load_val = clamp(bus.half_period);
    assign toggle   = bus.en && (cnt == (hp - ONE));

    // hp only changes at a toggle, so the running half-period always completes at its old length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            hp      <= HP_INIT;
            pending <= HP_INIT;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (bus.load) begin
                pending <= load_val;
            end
            if (toggle) begin
                cnt    <= '0;
                clk_q  <= ~clk_q;
                hp     <= bus.load ? load_val : pending;
                rise_q <= ~clk_q;
                fall_q <= clk_q;
            end else if (bus.en) begin
                cnt <= cnt + ONE;
            end
        end
    end

    assign bus.clk_out   = clk_q;
    assign bus.tick_rise = rise_q;
    assign bus.tick_fall = fall_q;

`ifdef CLOCK_GEN_PERIOD_COUNT_EN
    logic [31:0] period_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= 32'd0;
        end else if (toggle && !clk_q) begin
            period_q <= period_q + 32'd1;
        end
    end

    assign bus.period_count = period_q;
`else
    assign bus.period_count = 32'd0;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Bench for clock_gen: per-cycle model scoreboard, a vector table, and test-plan corner sequences.
module tb_clock_gen;
    localparam int CNT_W = 16;
    localparam int TR    = 10;

`ifdef CLOCK_GEN_PERIOD_COUNT_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    clock_gen_if #(.CNT_W(CNT_W)) bus ();

    clock_gen #(.TICK_RATE(TR), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          c;
        bit          r;
        bit          f;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        bit en;
        bit load;
        int hpv;
        bit e_clk;
        bit e_rise;
        bit e_fall;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[15];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no;

    bit          lg_clk  [0:63];
    bit          lg_rise [0:63];
    bit          lg_fall [0:63];
    logic [31:0] lg_pc   [0:63];

    // Behavioural model state
    int          m_cnt, m_hp, m_pend;
    bit          m_clk, m_rise, m_fall;
    logic [31:0] m_pc;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_hp   = TR;
        m_pend = TR;
        m_clk  = 0;
        m_rise = 0;
        m_fall = 0;
        m_pc   = 0;
        sb_q.delete();
        cyc_no = 0;
    endtask

    task automatic model_step(input bit e, input bit l, input int v);
        int cl;
        cl     = (v == 0) ? 1 : v;
        m_rise = 0;
        m_fall = 0;
        if (e) begin
            if (m_cnt == m_hp - 1) begin
                m_cnt = 0;
                m_hp  = l ? cl : m_pend;
                if (!m_clk) begin
                    m_rise = 1;
                    m_pc   = m_pc + 1;
                end else begin
                    m_fall = 1;
                end
                m_clk = !m_clk;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (l) m_pend = cl;
    endtask

    // One reference cycle: drive, predict, clock, then compare against the popped prediction.
    task automatic cyc(input bit e, input bit l, input int v);
        exp_t x;
        bus.en          = e;
        bus.load        = l;
        bus.half_period = CNT_W'(v);
        model_step(e, l, v);
        sb_q.push_back('{c: m_clk, r: m_rise, f: m_fall, pc: (PC_EN ? m_pc : 32'd0)});
        @(posedge clk);
        #1;
        cyc_no++;
        lg_clk[cyc_no]  = bus.clk_out;
        lg_rise[cyc_no] = bus.tick_rise;
        lg_fall[cyc_no] = bus.tick_fall;
        lg_pc[cyc_no]   = bus.period_count;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            x = sb_q.pop_front();
            chk("sb_clk_out",      bus.clk_out,      x.c);
            chk("sb_tick_rise",    bus.tick_rise,    x.r);
            chk("sb_tick_fall",    bus.tick_fall,    x.f);
            chk("sb_period_count", bus.period_count, x.pc);
        end
    endtask

    task automatic do_reset();
        bus.en          = 1'b0;
        bus.load        = 1'b0;
        bus.half_period = '0;
        rst_n = 1'b0;
        #12;
        model_reset();
        rst_n = 1'b1;
        #3;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0);
    endtask

    initial begin
        int cnt_r;
        bus.en          = 1'b0;
        bus.load        = 1'b0;
        bus.half_period = '0;
        rst_n           = 1'b0;
        model_reset();
        #3;
        chk("reset_clk_out",      bus.clk_out,      0);
        chk("reset_tick_rise",    bus.tick_rise,    0);
        chk("reset_tick_fall",    bus.tick_fall,    0);
        chk("reset_period_count", bus.period_count, 0);

        // Vector table: load hp=2 on cycle 1, en dropped on cycle 12
        tbl[0] = '{1, 1, 2, 0, 0, 0};
        for (int i = 1; i < 9; i++) tbl[i] = '{1, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 1, 1, 0};
        tbl[10] = '{1, 0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 1};
        tbl[13] = '{1, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].en, tbl[i].load, tbl[i].hpv);
            chk($sformatf("tbl%0d_clk_out", i + 1), bus.clk_out,   tbl[i].e_clk);
            chk($sformatf("tbl%0d_rise", i + 1),    bus.tick_rise, tbl[i].e_rise);
            chk($sformatf("tbl%0d_fall", i + 1),    bus.tick_fall, tbl[i].e_fall);
        end

        // Reset default: rise at 10, fall at 20, rise at 30
        do_reset();
        run(30);
        cnt_r = 0;
        for (int i = 1; i <= 30; i++) cnt_r += lg_rise[i];
        chk("def_rise_count", cnt_r, 2);
        chk("def_clk_9",   lg_clk[9],   0);
        chk("def_rise_10", lg_rise[10], 1);
        chk("def_fall_20", lg_fall[20], 1);
        chk("def_clk_20",  lg_clk[20],  0);
        chk("def_rise_30", lg_rise[30], 1);

        // Reload mid half-period
        do_reset();
        run(3);
        cyc(1'b1, 1'b1, 3);
        run(15);
        chk("rld_rise_10", lg_rise[10], 1);
        chk("rld_clk_12",  lg_clk[12],  1);
        chk("rld_fall_13", lg_fall[13], 1);
        chk("rld_rise_16", lg_rise[16], 1);
        chk("rld_fall_19", lg_fall[19], 1);

        // Zero clamp
        do_reset();
        cyc(1'b1, 1'b1, 0);
        run(13);
        chk("zc_rise_10", lg_rise[10], 1);
        chk("zc_fall_11", lg_fall[11], 1);
        chk("zc_rise_12", lg_rise[12], 1);
        chk("zc_fall_13", lg_fall[13], 1);
        chk("zc_rise_14", lg_rise[14], 1);

        // Enable gating for cycles 7..11
        do_reset();
        run(6);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 0);
        run(5);
        cnt_r = 0;
        for (int i = 7; i <= 11; i++) cnt_r += lg_rise[i] + lg_fall[i] + lg_clk[i];
        chk("gate_quiet", cnt_r, 0);
        chk("gate_clk_14",  lg_clk[14],  0);
        chk("gate_rise_15", lg_rise[15], 1);

        // Async reset mid-run while clk_out=1 and hp=3
        do_reset();
        cyc(1'b1, 1'b1, 3);
        run(10);
        chk("ar_pre_clk", bus.clk_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_clk_out",      bus.clk_out,      0);
        chk("ar_period_count", bus.period_count, 0);
        chk("ar_tick_rise",    bus.tick_rise,    0);
        model_reset();
        #1;
        rst_n = 1'b1;
        run(10);
        chk("ar_clk_9",   lg_clk[9],   0);
        chk("ar_rise_10", lg_rise[10], 1);

        // Period counter with hp=1
        do_reset();
        cyc(1'b1, 1'b1, 0);
        run(17);
        chk("pc_at_10", lg_pc[10], PC_EN ? 1 : 0);
        chk("pc_at_18", lg_pc[18], PC_EN ? 5 : 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
